// File: rtl/vram_painter.sv
// Touch-driven VRAM painter: clears the frame buffer after reset or on request,
// and paints BRUSH x BRUSH squares at accepted touch positions, one write per cycle.
package vram_painter_pkg;
  typedef logic [15:0] ILI9341_color_t;
  typedef struct packed {
    logic        valid;
    logic [15:0] x;
    logic [15:0] y;
  } touch_t;
endpackage

module vram_painter
  import vram_painter_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int BRUSH          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  touch_t                    touch,
  input  ILI9341_color_t            brush_color,
  input  ILI9341_color_t            bg_color,
  input  logic                      clear_req,
  output logic                      vram_wr_ena,
  output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
  output logic [15:0]               vram_wr_data,
  output logic                      busy
);

  localparam int AW = $clog2(VRAM_L);
  localparam int XW = $clog2(DISPLAY_WIDTH);
  localparam int YW = $clog2(DISPLAY_HEIGHT);
  localparam int BB = $clog2(BRUSH);
  localparam int PW = (BB > 0) ? BB : 1;

  localparam logic [15:0]   W16    = 16'(DISPLAY_WIDTH);
  localparam logic [15:0]   H16    = 16'(DISPLAY_HEIGHT);
  localparam logic [XW-1:0] X_MASK = XW'(~(BRUSH - 1));
  localparam logic [YW-1:0] Y_MASK = YW'(~(BRUSH - 1));
  localparam logic [PW-1:0] P_LAST = PW'(BRUSH - 1);
  localparam logic [AW-1:0] A_LAST = AW'(VRAM_L - 1);
  localparam logic [AW-1:0] A_W    = AW'(DISPLAY_WIDTH);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PAINT} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  clr_addr_q, clr_addr_d;
  logic [PW-1:0]  px_q, px_d, py_q, py_d;
  logic [XW-1:0]  x0_q, x0_d;
  logic [YW-1:0]  y0_q, y0_d;
  logic [15:0]    color_q, color_d;
  logic           pend_q, pend_d;
  logic           hist_q, hist_d;
  logic           wr_ena_q, wr_ena_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [15:0]    wr_data_q, wr_data_d;

  logic           clear_rise;
  logic           pend_now;
  logic           touch_ok;
  logic [AW-1:0]  paint_addr;

  // Touch is valid-only: it is taken on an enabled edge in S_IDLE with no clear
  // pending and in-range coordinates; anything presented while busy is dropped.
  assign touch_ok   = touch.valid && (touch.x < W16) && (touch.y < H16);
  assign clear_rise = clear_req & ~hist_q;
  assign pend_now   = pend_q | clear_rise;
  assign paint_addr = (AW'(y0_q) + AW'(py_q)) * A_W + AW'(x0_q) + AW'(px_q);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    px_d       = px_q;
    py_d       = py_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    color_d    = color_q;
    pend_d     = pend_q;
    hist_d     = hist_q;
    wr_ena_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (ena) begin
      hist_d = clear_req;
      pend_d = pend_now;
      case (state_q)
        S_CLEAR: begin
          wr_ena_d  = 1'b1;
          wr_addr_d = clr_addr_q;
          wr_data_d = bg_color;
          // Completion swallows any request raised during the sweep.
          if (clr_addr_q == A_LAST) begin
            clr_addr_d = '0;
            pend_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            clr_addr_d = clr_addr_q + AW'(1);
          end
        end
        S_IDLE: begin
          if (pend_now) begin
            clr_addr_d = '0;
            state_d    = S_CLEAR;
          end else if (touch_ok) begin
            x0_d    = touch.x[XW-1:0] & X_MASK;
            y0_d    = touch.y[YW-1:0] & Y_MASK;
            color_d = brush_color;
            px_d    = '0;
            py_d    = '0;
            state_d = S_PAINT;
          end
        end
        S_PAINT: begin
          wr_ena_d  = 1'b1;
          wr_addr_d = paint_addr;
          wr_data_d = color_q;
          if (px_q == P_LAST) begin
            px_d = '0;
            if (py_q == P_LAST) begin
              py_d    = '0;
              state_d = S_IDLE;
            end else begin
              py_d = py_q + PW'(1);
            end
          end else begin
            px_d = px_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      px_q       <= '0;
      py_q       <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      color_q    <= '0;
      pend_q     <= 1'b0;
      hist_q     <= 1'b0;
      wr_ena_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      px_q       <= px_d;
      py_q       <= py_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      color_q    <= color_d;
      pend_q     <= pend_d;
      hist_q     <= hist_d;
      wr_ena_q   <= wr_ena_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign vram_wr_ena  = wr_ena_q;
  assign vram_wr_addr = wr_addr_q;
  assign vram_wr_data = wr_data_q;

endmodule

// File: tb/tb_vram_painter.sv
// Bench for vram_painter on a 240x24 display: every VRAM write is checked
// in order against a queue of expected {address, data} words.
module tb_vram_painter;
  import vram_painter_pkg::*;

  localparam int W  = 240;
  localparam int H  = 24;
  localparam int B  = 4;
  localparam int VL = W * H;
  localparam int AW = $clog2(VL);

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  touch_t         touch;
  logic [15:0]    brush_color;
  logic [15:0]    bg_color;
  logic           clear_req;
  logic           vram_wr_ena;
  logic [AW-1:0]  vram_wr_addr;
  logic [15:0]    vram_wr_data;
  logic           busy;

  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] mon_exp;
  int             n_checks = 0;
  int             n_errors = 0;
  int             n_writes = 0;
  int             last_wr_addr = 0;
  int             w0;

  vram_painter #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .VRAM_L        (VL),
    .BRUSH         (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .touch       (touch),
    .brush_color (brush_color),
    .bg_color    (bg_color),
    .clear_req   (clear_req),
    .vram_wr_ena (vram_wr_ena),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .busy        (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop one expected word per observed write
  always @(negedge clk) begin
    if (!rst && vram_wr_ena) begin
      n_writes++;
      last_wr_addr = int'(vram_wr_addr);
      check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("wr_addr_data", 32'({vram_wr_addr, vram_wr_data}), 32'(mon_exp));
      end
    end
  end

  task automatic push_sweep(input logic [15:0] color);
    for (int a = 0; a < VL; a++) exp_q.push_back({AW'(a), color});
  endtask

  task automatic push_stroke(input int x, input int y, input logic [15:0] color);
    int x0, y0;
    x0 = (x / B) * B;
    y0 = (y / B) * B;
    for (int r = 0; r < B; r++)
      for (int c = 0; c < B; c++)
        exp_q.push_back({AW'((y0 + r) * W + x0 + c), color});
  endtask

  // Drive one accepted touch; returns on the negedge between accept and first write.
  task automatic start_touch(input int x, input int y, input logic [15:0] color);
    @(negedge clk);
    touch.valid = 1'b1;
    touch.x     = 16'(x);
    touch.y     = 16'(y);
    brush_color = color;
    push_stroke(x, y, color);
    @(posedge clk);
    #1 touch.valid = 1'b0;
    @(negedge clk);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_no_wr", 32'(vram_wr_ena), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 8000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    exp_q.delete();
    @(negedge clk);
    check({tag, "_idle_wr_ena"}, 32'(vram_wr_ena), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_addr(input int addr, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      @(negedge clk);
      if (vram_wr_ena && int'(vram_wr_addr) == addr) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic quiet(input int n, input string tag);
    bit saw = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    check(tag, 32'(saw), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    ena         = 1'b0;
    touch       = '0;
    brush_color = '0;
    bg_color    = '0;
    clear_req   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_wr_ena", 32'(vram_wr_ena), 32'd0);
    check("rst_addr", 32'(vram_wr_addr), 32'd0);
    check("rst_data", 32'(vram_wr_data), 32'd0);

    // power-up sweep of black
    push_sweep(16'h0000);
    rst = 1'b0;
    ena = 1'b1;
    wait_idle("sweep0");

    // basic stroke; colour change after acceptance must not leak in
    w0 = n_writes;
    start_touch(10, 21, 16'hF800);
    brush_color = 16'h001F;
    @(negedge clk);
    check("first_addr", 32'(vram_wr_addr), 32'd4808);
    check("first_data", 32'(vram_wr_data), 32'h0000_F800);
    wait_idle("stroke0");
    check("stroke0_count", 32'(n_writes - w0), 32'd16);
    check("stroke0_last", 32'(last_wr_addr), 32'd5531);

    // out-of-range touches are ignored
    @(negedge clk);
    touch.valid = 1'b1; touch.x = 16'd250; touch.y = 16'd5;
    @(negedge clk);
    touch.x = 16'd5; touch.y = 16'(H);
    @(negedge clk);
    touch.valid = 1'b0;
    quiet(10, "oor_busy");

    // far corner square
    start_touch(W - 1, H - 1, 16'h07E0);
    wait_idle("corner");

    // touches while busy are dropped
    start_touch(100, 3, 16'h1111);
    @(negedge clk);
    touch.valid = 1'b1; touch.x = 16'd40; touch.y = 16'd8;
    repeat (3) @(negedge clk);
    touch.valid = 1'b0;
    wait_idle("drop");
    quiet(5, "drop_quiet");

    // clear request mid-stroke: stroke finishes, then one sweep; held level is ignored
    bg_color = 16'hA5A5;
    start_touch(60, 12, 16'h3C3C);
    brush_color = 16'hC3C3;
    repeat (5) @(negedge clk);
    clear_req = 1'b1;
    push_sweep(16'hA5A5);
    wait_idle("paint_then_clear");
    quiet(30, "held_no_retrigger");
    clear_req = 1'b0;

    // enable stall mid-sweep, bg change mid-sweep, request during sweep
    bg_color = 16'h07E0;
    @(negedge clk);
    clear_req = 1'b1;
    push_sweep(16'h07E0);
    @(negedge clk);
    clear_req = 1'b0;
    wait_addr(1000, "reach_1000");
    ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_wr_ena", 32'(vram_wr_ena), 32'd0);
    end
    ena = 1'b1;
    @(negedge clk);
    check("resume_wr_ena", 32'(vram_wr_ena), 32'd1);
    check("resume_addr", 32'(vram_wr_addr), 32'd1001);
    #1;
    bg_color = 16'hF0F0;
    foreach (exp_q[i]) exp_q[i][15:0] = 16'hF0F0;
    wait_addr(3000, "reach_3000");
    clear_req = 1'b1;
    wait_idle("sweep_stall");
    quiet(30, "clear_during_clear");
    clear_req = 1'b0;

    // asynchronous reset during the 7th write of a stroke
    start_touch(120, 16, 16'h5555);
    repeat (7) @(negedge clk);
    #1;
    check("pre_rst_left", 32'(exp_q.size()), 32'd9);
    rst = 1'b1;
    #1;
    check("async_rst_wr_ena", 32'(vram_wr_ena), 32'd0);
    check("async_rst_addr", 32'(vram_wr_addr), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    bg_color = 16'h0F0F;
    push_sweep(16'h0F0F);
    rst = 1'b0;
    @(negedge clk);
    check("restart_wr_ena", 32'(vram_wr_ena), 32'd1);
    check("restart_addr", 32'(vram_wr_addr), 32'd0);
    wait_idle("sweep_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vram_painter.md
VRAM_PAINTER -- requirements
Module: vram_painter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DISPLAY_WIDTH, 240, pixels per row.
  DISPLAY_HEIGHT, 320, rows.
  VRAM_L, DISPLAY_WIDTH*DISPLAY_HEIGHT, VRAM words.
  BRUSH, 4, brush edge in pixels; a power of two that divides both display dimensions.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  input  1  single clock; all logic is on posedge.
  rst  input  1  reset, asynchronous, active-high.
  ena  input  1  advance enable.
  touch  input  touch_t  touch event: valid, x, y.
  brush_color  input  16 (ILI9341_color_t)  paint colour.
  bg_color  input  16 (ILI9341_color_t)  clear colour.
  clear_req  input  1  level request to clear the screen.
  vram_wr_ena  output  1  VRAM write strobe.
  vram_wr_addr  output  $clog2(VRAM_L)  VRAM write address.
  vram_wr_data  output  16  VRAM write data.
  busy  output  1  high in any state other than S_IDLE.

Function
REQ-003 The state machine SHALL have exactly three states: S_CLEAR, S_IDLE and S_PAINT.
REQ-004 vram_wr_ena, vram_wr_addr and vram_wr_data SHALL be registered outputs.
REQ-005 Every write SHALL use address y*DISPLAY_WIDTH + x, computed at full width with no truncation.
REQ-006 busy SHALL be combinational, equal to (state != S_IDLE).
REQ-007 When ena is low, all state, counters and latches SHALL hold, and vram_wr_ena SHALL be 0 on the next edge.
REQ-008 S_CLEAR: the block SHALL write bg_color to addresses 0..VRAM_L-1 in ascending order, one write per enabled cycle.
REQ-009 S_CLEAR: after the write to VRAM_L-1, the block SHALL go to S_IDLE and clear the pending-clear flag.
REQ-010 S_IDLE: if a clear is pending, the block SHALL enter S_CLEAR. Clear has priority over a touch sampled on the same edge.
REQ-011 S_IDLE: otherwise, if touch.valid=1, touch.x < DISPLAY_WIDTH and touch.y < DISPLAY_HEIGHT, the block SHALL accept the touch.
REQ-012 On acceptance the block SHALL latch:
  x0 = touch.x rounded down to a multiple of BRUSH;
  y0 = touch.y rounded down to a multiple of BRUSH;
  brush_color.
  It SHALL then enter S_PAINT.
REQ-013 A valid touch with out-of-range coordinates SHALL be ignored: no write, and the state stays S_IDLE.
REQ-014 S_PAINT: the block SHALL write the latched colour to the BRUSH x BRUSH square at (x0,y0), row-major (x fastest), one write per enabled cycle.
REQ-015 S_PAINT: after BRUSH*BRUSH writes the block SHALL return to S_IDLE. No clipping is needed, because BRUSH divides both display dimensions.
REQ-016 Latency: the first write (vram_wr_ena=1) SHALL appear on the edge following the accepting edge. A full stroke occupies exactly BRUSH*BRUSH enabled cycles.
REQ-017 Touches presented while busy=1 SHALL be dropped, not queued.
REQ-018 A rising edge of clear_req SHALL set the pending-clear flag; a clear_req held high SHALL NOT retrigger.
REQ-019 clear_req rising during S_PAINT SHALL NOT abort the stroke: the stroke completes, then S_IDLE acts on the pending clear.
REQ-020 clear_req rising during S_CLEAR SHALL set the pending-clear flag, which the completion in REQ-009 clears, so the sweep is not restarted.
REQ-021 vram_wr_ena SHALL be 0 in S_IDLE.
REQ-022 brush_color and bg_color changes mid-stroke SHALL NOT affect the current stroke. bg_color SHALL be sampled on every clear write.

Reset
REQ-023 While rst=1, asynchronously:
  state = S_CLEAR;
  clear address counter = 0;
  paint counters = 0;
  pending-clear flag = 0;
  clear_req edge history = 0;
  vram_wr_ena = 0, vram_wr_addr = 0, vram_wr_data = 0;
  busy = 1.
REQ-024 Reset asserted mid-operation SHALL abandon any stroke or sweep. After release the block SHALL perform a full clear from address 0.

Verification
REQ-025 Reset release with ena=1 and bg_color=16'h0000 -> 76800 consecutive writes of 0x0000 at addresses 0..76799. Then busy=0 and vram_wr_ena=0.
REQ-026 Touch accepted in S_IDLE with x=10, y=21, brush_color=16'hF800 -> 16 writes of 0xF800. Rows y=20..23, x=8..11. First address 4808, last address 5531. Then S_IDLE.
REQ-027 Touch with valid=1 and x=250, y=5 -> no write, and busy stays 0.
REQ-028 clear_req pulse during the 5th write of a stroke -> the remaining 11 writes of the stroke complete, then the 76800-write sweep runs. clear_req held high afterwards -> no second sweep.
REQ-029 ena low for 3 cycles at sweep address 1000 -> vram_wr_ena=0 for those cycles. Writes resume at 1001 with no gap or repeat.
REQ-030 rst asserted during the 7th write of a stroke -> vram_wr_ena=0 immediately, without waiting for a clk edge. After release the sweep restarts at address 0.
